adder_share_arbiter: RTL
========================

Name: adder_share_arbiter

Overview:
- Time-multiplexes the single 32-bit carry-select adder (CSA32) between NREQ requesters in the pipelined datapath.
- Uses round-robin arbitration, a valid/ready handshake on each request port and one shared response channel with backpressure.
- Sequences the adder for both 32-bit (one pass) and 64-bit (two passes, carry chained) additions.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, adder width; fixed at 32 to match CSA32.
- IDW, 2, requester-ID width; equals clog2(NREQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant/accept; one-hot or zero.
- req_a  input  NREQ*2*W  operand A; requester i occupies bits [i*64 +: 64].
- req_b  input  NREQ*2*W  operand B, same packing as req_a.
- req_cin  input  NREQ  carry-in per requester.
- req_wide  input  NREQ  1 = 64-bit add, 0 = 32-bit add (upper operand halves ignored).
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  IDW  index of the requester that owns the result.
- resp_sum  output  2*W  sum; bits [63:32] are zero for narrow ops.
- resp_cout  output  1  final carry-out.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr=0, operand/result registers 0. Assertion is asynchronous at any point, including mid-op: the in-flight op is discarded and resp_valid drops immediately; the requester must re-issue.
- FSM states: IDLE, LO, HI, RESP.
- IDLE:
  - If any req_valid, the winner is the first requester with valid set, searching from rr_ptr upward with wrap mod NREQ.
  - req_ready[winner]=1 combinationally in this cycle and the handshake completes.
  - Latch a, b, cin, wide and id for the winner, then go to LO.
  - If no req_valid, stay in IDLE with req_ready=0.
- req_ready is 0 in every state other than IDLE. Requesters hold valid and operands stable until ready.
- LO:
  - Adder inputs: a_q[31:0], b_q[31:0], cin_q.
  - Register sum_lo and carry_q = c[31].
  - wide_q=1 goes to HI; otherwise go to RESP with sum_hi=0 and cout=carry_q.
- HI:
  - Adder inputs: a_q[63:32], b_q[63:32], carry-in = carry_q.
  - Register sum_hi and cout = c[31], then go to RESP.
- RESP:
  - resp_valid=1; resp_id, resp_sum and resp_cout stay stable while resp_ready=0.
  - On resp_valid && resp_ready: go to IDLE, clear resp_valid and set rr_ptr = (id_q+1) mod NREQ.
- Latency: with the handshake in cycle T, resp_valid rises at T+2 for narrow ops and T+3 for wide ops.
- Minimum issue interval (resp_ready held high): 3 cycles narrow, 4 cycles wide.
- Simultaneous requests: exactly one grant per IDLE cycle; the losers keep valid asserted and wait.
- A requester that drops valid before its grant is never granted.
- The adder carry-in is cin_q in LO and carry_q in HI; its operand inputs are zero in IDLE/RESP to limit toggling.
- Width rule: all arithmetic is unsigned modulo 2^32 per pass; overflow appears only in resp_cout.

Decomposition:
- Shared package/header holds:
  - the state encoding (IDLE=2'd0, LO=2'd1, HI=2'd2, RESP=2'd3),
  - the W and default NREQ constants,
  - the IDW derivation.
- One natural sub-module: rr_pick (NREQ valids + rr_ptr -> one-hot grant + encoded index), purely combinational.
- The adder is instantiated directly as CSA32.

Test Plan:
1. Narrow carry: req0 with a=0x0000_0000_FFFF_FFFF, b=0x1, cin=0, wide=0 -> at T+2 resp_valid=1, resp_id=0, resp_sum=0, resp_cout=1.
2. Wide carry propagation: req1 with a=0x0000_0000_FFFF_FFFF, b=0x1, wide=1 -> at T+3 resp_sum=0x0000_0001_0000_0000, resp_cout=0, resp_id=1.
3. Wide overflow: a=b=0xFFFF_FFFF_FFFF_FFFF, cin=1, wide=1 -> resp_sum=0xFFFF_FFFF_FFFF_FFFF, resp_cout=1.
4. Round-robin: all 4 req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0; a new grant every 3 cycles for narrow ops.
5. Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_* held stable, req_ready stays 0 for all requesters, busy=1; releasing resp_ready -> IDLE on the next edge.
6. Reset mid-op: pull rst_n low during HI -> resp_valid=0 and busy=0 immediately; after release, req2 and req0 both valid -> req0 granted first (rr_ptr=0).

Source files
------------

// File: rtl/adder_share_arbiter_pkg.sv
// Shared constants, state encoding and ID-width derivation for the adder-sharing arbiter.
package adder_share_arbiter_pkg;

    localparam int unsigned CsaWidth    = 32;
    localparam int unsigned DefaultNreq = 4;

    // A single requester still needs a 1-bit ID field.
    function automatic int unsigned idw_of(input int unsigned nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLo   = 2'd1,
        StHi   = 2'd2,
        StResp = 2'd3
    } state_e;

endpackage

// File: rtl/adder_share_arbiter_csa32.sv
// 32-bit carry-select adder: 16-bit low half ripples, high half is precomputed for both carries.
module CSA32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    logic [16:0] lo;
    logic [16:0] hi0;
    logic [16:0] hi1;

    always_comb begin
        lo  = 17'(a_i[15:0]) + 17'(b_i[15:0]) + 17'(cin_i);
        hi0 = 17'(a_i[31:16]) + 17'(b_i[31:16]);
        hi1 = 17'(a_i[31:16]) + 17'(b_i[31:16]) + 17'd1;
        sum_o[15:0] = lo[15:0];
        if (lo[16]) begin
            sum_o[31:16] = hi1[15:0];
            cout_o       = hi1[16];
        end else begin
            sum_o[31:16] = hi0[15:0];
            cout_o       = hi0[16];
        end
    end

endmodule

// File: rtl/adder_share_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or above ptr_i, wrapping mod NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    int unsigned j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = 32'(ptr_i) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any_o && valid_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one CSA32 between NREQ requesters; 64-bit adds take two passes with the carry chained.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = DefaultNreq,
    parameter int unsigned W    = CsaWidth,
    parameter int unsigned IDW  = idw_of(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*2*W-1:0] req_a,
    input  logic [NREQ*2*W-1:0] req_b,
    input  logic [NREQ-1:0]     req_cin,
    input  logic [NREQ-1:0]     req_wide,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDW-1:0]      resp_id,
    output logic [2*W-1:0]      resp_sum,
    output logic                resp_cout,
    output logic                busy
);

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [2*W-1:0] a_q, a_d;
    logic [2*W-1:0] b_q, b_d;
    logic [2*W-1:0] sum_q, sum_d;
    logic           cin_q, cin_d;
    logic           wide_q, wide_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;

    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_cout;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    CSA32 u_csa32 (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cin_d     = cin_q;
        wide_d    = wide_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        req_ready = '0;
        // Adder operands idle at zero outside LO/HI to keep it from toggling.
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_any) begin
                    req_ready = grant;
                    a_d       = req_a[int'(grant_idx)*2*W +: 2*W];
                    b_d       = req_b[int'(grant_idx)*2*W +: 2*W];
                    cin_d     = req_cin[grant_idx];
                    wide_d    = req_wide[grant_idx];
                    id_d      = grant_idx;
                    state_d   = StLo;
                end
            end
            StLo: begin
                add_a          = a_q[W-1:0];
                add_b          = b_q[W-1:0];
                add_cin        = cin_q;
                sum_d[W-1:0]   = add_sum;
                carry_d        = add_cout;
                if (wide_q) begin
                    state_d = StHi;
                end else begin
                    sum_d[2*W-1:W] = '0;
                    cout_d         = add_cout;
                    state_d        = StResp;
                end
            end
            StHi: begin
                add_a          = a_q[2*W-1:W];
                add_b          = b_q[2*W-1:W];
                add_cin        = carry_q;
                sum_d[2*W-1:W] = add_sum;
                cout_d         = add_cout;
                state_d        = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d  = StIdle;
                    rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            cin_q    <= 1'b0;
            wide_q   <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            cin_q    <= cin_d;
            wide_q   <= wide_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
        end
    end

    assign resp_valid = (state_q == StResp);
    assign busy       = (state_q != StIdle);
    assign resp_id    = id_q;
    assign resp_sum   = sum_q;
    assign resp_cout  = cout_q;

endmodule
